enc_tx_sequencer: RTL and testbench
===================================

ENC_TX_SEQUENCER -- requirements
Module: enc_tx_sequencer

Interface
REQ-001 Parameter ALIGN_PERIOD, default 256: payload bytes between forced K28.5 alignment symbols inside a packet (legal 2..65535).
REQ-002 clk  input  1  single clock for the block and the downstream 8b10b encoder.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 link_en  input  1  high permits a new packet to start; sampled only in IDLE.
REQ-005 tx_valid  input  1  upstream byte valid.
REQ-006 tx_data  input  8  upstream payload byte.
REQ-007 tx_last  input  1  qualifies the final byte of a packet; meaningful only with tx_valid.
REQ-008 tx_ready  output  1  byte accepted on an edge where tx_valid and tx_ready are both high.
REQ-009 enc_k  output  1  K/D select to encoder k_in.
REQ-010 enc_data  output  8  symbol to encoder data_in.
REQ-011 enc_k_err  input  1  encoder K-symbol error flag.
REQ-012 err_clr  input  1  clears err_sticky.
REQ-013 err_sticky  output  1  latched encoder K error.
REQ-014 pkt_cnt  output  16  completed-packet count (EOP symbols issued).

Function
REQ-015 Symbol codes: IDLE K28.5 = 0xBC, SOP K27.7 = 0xFB, EOP K29.7 = 0xFD, FILL K23.7 = 0xF7, ALIGN K28.5 = 0xBC; all sent with enc_k=1; payload sent with enc_k=0.
REQ-016 enc_k/enc_data shall be registered; each edge loads the symbol chosen by current state and inputs; one symbol per cycle, no gaps.
REQ-017 FSM states IDLE, SOP, DATA, ALIGN, EOP.
REQ-018 IDLE: load IDLE symbol; tx_ready=0; if link_en and tx_valid go to SOP, else stay.
REQ-019 SOP: load SOP symbol; tx_ready=0; go to DATA; align counter cleared.
REQ-020 DATA: tx_ready=1 combinationally; with tx_valid load D tx_data and increment align counter; without tx_valid load FILL and stay in DATA.
REQ-021 DATA with accepted byte and tx_last=1: go to EOP; align counter cleared (tx_last takes priority over alignment).
REQ-022 DATA with accepted byte, tx_last=0, align counter at ALIGN_PERIOD-1: go to ALIGN, clear counter.
REQ-023 ALIGN: load ALIGN symbol; tx_ready=0; return to DATA.
REQ-024 EOP: load EOP symbol; tx_ready=0; increment pkt_cnt (wraps 0xFFFF -> 0x0000); go to IDLE.
REQ-025 Latency: accepted byte appears on enc_data exactly one cycle after the accepting edge.
REQ-026 link_en falling mid-packet shall not abort; packet completes through EOP.
REQ-027 err_sticky sets on any edge with enc_k_err=1; err_clr clears it; simultaneous set and clear -> set wins.
REQ-028 Align counter 16 bits, never exceeds ALIGN_PERIOD-1.

Reset
REQ-029 On rst_n low, immediately: state IDLE, enc_k=1, enc_data=0xBC, tx_ready=0, align counter 0, pkt_cnt 0, err_sticky 0.
REQ-030 Reset mid-packet discards the packet; no EOP issued; first post-reset symbol is IDLE.
REQ-031 Upstream may hold tx_valid through reset; no byte is accepted before SOP.

Structure
REQ-032 Symbol codes (REQ-015) and the FSM state enumeration shall live in the shared package enc_pkg.
REQ-033 Single flat module; no sub-module; instantiated beside encoder_8b10b, driving its k_in/data_in and monitoring its k_err.

Verification
REQ-034 Reset then link_en=1, 3-byte packet 0x11,0x22,0x33(last) back-to-back -> enc_data BC,FB,11,22,33,FD,BC; enc_k 1,1,0,0,0,1,1; pkt_cnt=1.
REQ-035 ALIGN_PERIOD=4, 6-byte packet 0x01..0x06 -> FB,01,02,03,04,BC(k),05,06,FD; tx_ready low during ALIGN cycle.
REQ-036 ALIGN_PERIOD=4, last byte is the 4th -> FB,01,02,03,04,FD with no ALIGN inserted.
REQ-037 tx_valid gap of 2 cycles mid-packet -> two F7 (k=1) symbols, payload order preserved, no byte lost or duplicated.
REQ-038 Drop link_en mid-packet then assert rst_n low mid-next-packet -> first packet ends with FD; second aborts, enc_data=BC during/after reset, pkt_cnt=0.
REQ-039 Pulse enc_k_err once, then err_clr with concurrent enc_k_err -> err_sticky remains 1; err_clr alone next cycle -> 0.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared symbol codes and FSM state encoding for the 8b10b transmit path.
package enc_pkg;

  localparam logic [7:0] SYM_IDLE  = 8'hBC;  // K28.5
  localparam logic [7:0] SYM_SOP   = 8'hFB;  // K27.7
  localparam logic [7:0] SYM_EOP   = 8'hFD;  // K29.7
  localparam logic [7:0] SYM_FILL  = 8'hF7;  // K23.7
  localparam logic [7:0] SYM_ALIGN = 8'hBC;  // K28.5

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOP,
    ST_DATA,
    ST_ALIGN,
    ST_EOP
  } enc_state_t;

endpackage

// File: rtl/enc_tx_sequencer.sv
// Frames upstream payload bytes into SOP/DATA/ALIGN/EOP symbol streams for an
// 8b10b encoder, one registered symbol per clock.
module enc_tx_sequencer
  import enc_pkg::*;
#(
  parameter int unsigned ALIGN_PERIOD = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        link_en,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  input  logic        tx_last,
  output logic        tx_ready,
  output logic        enc_k,
  output logic [7:0]  enc_data,
  input  logic        enc_k_err,
  input  logic        err_clr,
  output logic        err_sticky,
  output logic [15:0] pkt_cnt
);

  localparam logic [15:0] ALIGN_LAST = 16'(ALIGN_PERIOD - 1);

  enc_state_t  state, state_nxt;
  logic [15:0] align_cnt, align_cnt_nxt;
  logic        sym_k;
  logic [7:0]  sym_data;
  logic        pkt_done;
  logic        accept;

  assign accept = tx_valid && tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      align_cnt <= '0;
      enc_k     <= 1'b1;
      enc_data  <= SYM_IDLE;
      pkt_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      align_cnt <= align_cnt_nxt;
      enc_k     <= sym_k;
      enc_data  <= sym_data;
      if (pkt_done) pkt_cnt <= pkt_cnt + 16'd1;
    end
  end

  // Set has priority so an error coinciding with a clear is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          err_sticky <= 1'b0;
    else if (enc_k_err)  err_sticky <= 1'b1;
    else if (err_clr)    err_sticky <= 1'b0;
  end

  always_comb begin
    state_nxt     = state;
    align_cnt_nxt = align_cnt;
    case (state)
      ST_IDLE:  if (link_en && tx_valid) state_nxt = ST_SOP;
      ST_SOP: begin
        state_nxt     = ST_DATA;
        align_cnt_nxt = '0;
      end
      ST_DATA: begin
        // End of packet wins over a due alignment symbol.
        if (accept) begin
          if (tx_last) begin
            state_nxt     = ST_EOP;
            align_cnt_nxt = '0;
          end else if (align_cnt == ALIGN_LAST) begin
            state_nxt     = ST_ALIGN;
            align_cnt_nxt = '0;
          end else begin
            align_cnt_nxt = align_cnt + 16'd1;
          end
        end
      end
      ST_ALIGN: state_nxt = ST_DATA;
      ST_EOP:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_ready = 1'b0;
    sym_k    = 1'b1;
    sym_data = SYM_IDLE;
    pkt_done = 1'b0;
    case (state)
      ST_IDLE:  sym_data = SYM_IDLE;
      ST_SOP:   sym_data = SYM_SOP;
      ST_DATA: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          sym_k    = 1'b0;
          sym_data = tx_data;
        end else begin
          sym_data = SYM_FILL;
        end
      end
      ST_ALIGN: sym_data = SYM_ALIGN;
      ST_EOP: begin
        sym_data = SYM_EOP;
        pkt_done = 1'b1;
      end
      default:  sym_data = SYM_IDLE;
    endcase
  end

endmodule

// File: tb/tb_enc_tx_sequencer.sv
// Directed self-checking bench for enc_tx_sequencer with a short alignment
// period so ALIGN insertion is reachable in a few bytes.
module tb_enc_tx_sequencer;

  logic        clk;
  logic        rst_n;
  logic        link_en;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_last;
  logic        tx_ready;
  logic        enc_k;
  logic [7:0]  enc_data;
  logic        enc_k_err;
  logic        err_clr;
  logic        err_sticky;
  logic [15:0] pkt_cnt;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  enc_tx_sequencer #(.ALIGN_PERIOD(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .link_en    (link_en),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_last    (tx_last),
    .tx_ready   (tx_ready),
    .enc_k      (enc_k),
    .enc_data   (enc_data),
    .enc_k_err  (enc_k_err),
    .err_clr    (err_clr),
    .err_sticky (err_sticky),
    .pkt_cnt    (pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_stimulus(input logic v, input logic [7:0] d, input logic l);
    tx_valid = v;
    tx_data  = d;
    tx_last  = l;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic k, input logic [7:0] d);
    vec_cnt++;
    assert ({enc_k, enc_data} === {k, d}) else begin
      miss_cnt++;
      $error("[TB] FAIL %s: observed k=%b data=%h, expected k=%b data=%h",
             tag, enc_k, enc_data, k, d);
    end
  endtask

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; link_en = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    tx_last = 1'b0; enc_k_err = 1'b0; err_clr = 1'b0;
    #12;
    check_output("reset_sym", 1'b1, 8'hBC);
    check_val("reset_rdy", 16'(tx_ready), 16'd0);
    check_val("reset_pkt", pkt_cnt, 16'd0);
    check_val("reset_err", 16'(err_sticky), 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Three-byte back-to-back packet.
    link_en = 1'b1;
    check_val("p1_idle_rdy", 16'(tx_ready), 16'd0);
    apply_stimulus(1'b1, 8'h11, 1'b0); check_output("p1_idle", 1'b1, 8'hBC);
    apply_stimulus(1'b1, 8'h11, 1'b0); check_output("p1_sop", 1'b1, 8'hFB);
    check_val("p1_data_rdy", 16'(tx_ready), 16'd1);
    apply_stimulus(1'b1, 8'h11, 1'b0); check_output("p1_b0", 1'b0, 8'h11);
    apply_stimulus(1'b1, 8'h22, 1'b0); check_output("p1_b1", 1'b0, 8'h22);
    apply_stimulus(1'b1, 8'h33, 1'b1); check_output("p1_b2", 1'b0, 8'h33);
    apply_stimulus(1'b0, 8'h00, 1'b0); check_output("p1_eop", 1'b1, 8'hFD);
    check_val("p1_pkt", pkt_cnt, 16'd1);
    apply_stimulus(1'b0, 8'h00, 1'b0); check_output("p1_post", 1'b1, 8'hBC);

    // Six bytes with alignment after the fourth.
    apply_stimulus(1'b1, 8'h01, 1'b0); check_output("p2_idle", 1'b1, 8'hBC);
    apply_stimulus(1'b1, 8'h01, 1'b0); check_output("p2_sop", 1'b1, 8'hFB);
    for (int i = 1; i <= 4; i++) begin
      apply_stimulus(1'b1, 8'(i), 1'b0); check_output("p2_byte", 1'b0, 8'(i));
    end
    check_val("p2_align_rdy", 16'(tx_ready), 16'd0);
    apply_stimulus(1'b1, 8'h05, 1'b0); check_output("p2_align", 1'b1, 8'hBC);
    apply_stimulus(1'b1, 8'h05, 1'b0); check_output("p2_b5", 1'b0, 8'h05);
    apply_stimulus(1'b1, 8'h06, 1'b1); check_output("p2_b6", 1'b0, 8'h06);
    apply_stimulus(1'b0, 8'h00, 1'b0); check_output("p2_eop", 1'b1, 8'hFD);
    check_val("p2_pkt", pkt_cnt, 16'd2);
    apply_stimulus(1'b0, 8'h00, 1'b0); check_output("p2_post", 1'b1, 8'hBC);

    // Last byte coincides with the alignment point: no ALIGN symbol.
    apply_stimulus(1'b1, 8'h01, 1'b0); check_output("p3_idle", 1'b1, 8'hBC);
    apply_stimulus(1'b1, 8'h01, 1'b0); check_output("p3_sop", 1'b1, 8'hFB);
    for (int i = 1; i <= 4; i++) begin
      apply_stimulus(1'b1, 8'(i), (i == 4)); check_output("p3_byte", 1'b0, 8'(i));
    end
    apply_stimulus(1'b0, 8'h00, 1'b0); check_output("p3_eop", 1'b1, 8'hFD);
    check_val("p3_pkt", pkt_cnt, 16'd3);
    apply_stimulus(1'b0, 8'h00, 1'b0); check_output("p3_post", 1'b1, 8'hBC);

    // Two-cycle valid gap produces FILL symbols.
    apply_stimulus(1'b1, 8'hA1, 1'b0); check_output("p4_idle", 1'b1, 8'hBC);
    apply_stimulus(1'b1, 8'hA1, 1'b0); check_output("p4_sop", 1'b1, 8'hFB);
    apply_stimulus(1'b1, 8'hA1, 1'b0); check_output("p4_b0", 1'b0, 8'hA1);
    apply_stimulus(1'b0, 8'hEE, 1'b0); check_output("p4_fill0", 1'b1, 8'hF7);
    apply_stimulus(1'b0, 8'hEE, 1'b1); check_output("p4_fill1", 1'b1, 8'hF7);
    apply_stimulus(1'b1, 8'hA2, 1'b0); check_output("p4_b1", 1'b0, 8'hA2);
    apply_stimulus(1'b1, 8'hA3, 1'b1); check_output("p4_b2", 1'b0, 8'hA3);
    apply_stimulus(1'b0, 8'h00, 1'b0); check_output("p4_eop", 1'b1, 8'hFD);
    check_val("p4_pkt", pkt_cnt, 16'd4);
    apply_stimulus(1'b0, 8'h00, 1'b0); check_output("p4_post", 1'b1, 8'hBC);

    // link_en dropped mid-packet must not abort it.
    apply_stimulus(1'b1, 8'hB1, 1'b0); check_output("p5_idle", 1'b1, 8'hBC);
    apply_stimulus(1'b1, 8'hB1, 1'b0); check_output("p5_sop", 1'b1, 8'hFB);
    apply_stimulus(1'b1, 8'hB1, 1'b0); check_output("p5_b0", 1'b0, 8'hB1);
    link_en = 1'b0;
    apply_stimulus(1'b1, 8'hB2, 1'b0); check_output("p5_b1", 1'b0, 8'hB2);
    apply_stimulus(1'b1, 8'hB3, 1'b1); check_output("p5_b2", 1'b0, 8'hB3);
    apply_stimulus(1'b1, 8'hC1, 1'b0); check_output("p5_eop", 1'b1, 8'hFD);
    check_val("p5_pkt", pkt_cnt, 16'd5);
    apply_stimulus(1'b1, 8'hC1, 1'b0); check_output("p5_post", 1'b1, 8'hBC);
    apply_stimulus(1'b1, 8'hC1, 1'b0); check_output("no_link_idle", 1'b1, 8'hBC);

    // Second packet aborted by reset with tx_valid held high throughout.
    link_en = 1'b1;
    apply_stimulus(1'b1, 8'hC1, 1'b0); check_output("p6_idle", 1'b1, 8'hBC);
    apply_stimulus(1'b1, 8'hC1, 1'b0); check_output("p6_sop", 1'b1, 8'hFB);
    apply_stimulus(1'b1, 8'hC1, 1'b0); check_output("p6_b0", 1'b0, 8'hC1);
    #2 rst_n = 1'b0;
    #1;
    check_output("p6_rst_sym", 1'b1, 8'hBC);
    check_val("p6_rst_pkt", pkt_cnt, 16'd0);
    check_val("p6_rst_rdy", 16'(tx_ready), 16'd0);
    apply_stimulus(1'b1, 8'hC2, 1'b1); check_output("p6_in_rst", 1'b1, 8'hBC);
    rst_n = 1'b1;
    check_val("p7_idle_rdy", 16'(tx_ready), 16'd0);
    apply_stimulus(1'b1, 8'hC2, 1'b1); check_output("p7_idle", 1'b1, 8'hBC);
    apply_stimulus(1'b1, 8'hC2, 1'b1); check_output("p7_sop", 1'b1, 8'hFB);
    check_val("p7_pkt_pre", pkt_cnt, 16'd0);
    apply_stimulus(1'b1, 8'hC2, 1'b1); check_output("p7_b0", 1'b0, 8'hC2);
    apply_stimulus(1'b0, 8'h00, 1'b0); check_output("p7_eop", 1'b1, 8'hFD);
    check_val("p7_pkt", pkt_cnt, 16'd1);

    // Sticky error: set wins over a concurrent clear.
    enc_k_err = 1'b1; apply_stimulus(1'b0, 8'h00, 1'b0);
    check_val("err_set", 16'(err_sticky), 16'd1);
    enc_k_err = 1'b0; apply_stimulus(1'b0, 8'h00, 1'b0);
    check_val("err_hold", 16'(err_sticky), 16'd1);
    enc_k_err = 1'b1; err_clr = 1'b1; apply_stimulus(1'b0, 8'h00, 1'b0);
    check_val("err_set_wins", 16'(err_sticky), 16'd1);
    enc_k_err = 1'b0; apply_stimulus(1'b0, 8'h00, 1'b0);
    check_val("err_clr", 16'(err_sticky), 16'd0);
    err_clr = 1'b0; apply_stimulus(1'b0, 8'h00, 1'b0);
    check_val("err_stay_clr", 16'(err_sticky), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
